// File: rtl/motor_cmd_scheduler.sv
// rtl/motor_cmd_scheduler.sv - fixed-priority frame scheduler for the motor-board SPI master
module motor_cmd_scheduler #(
    parameter int unsigned HEARTBEAT_CYCLES = 1_000_000,
    parameter int unsigned WATCHDOG_CYCLES  = 5_000_000,
    parameter int unsigned GAP_CYCLES       = 16,
    parameter int unsigned START_TIMEOUT    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        estop_req,
    input  logic        cnn_cmd_valid,
    input  logic [2:0]  cnn_cmd,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        watchdog_tripped,
    output logic [2:0]  last_cmd,
    output logic [15:0] frames_sent,
    output logic        sched_busy
);

    // Counters fire one cycle before they would reach the terminal value, then saturate there.
    localparam logic [31:0] HB_LAST  = 32'(HEARTBEAT_CYCLES - 1);
    localparam logic [31:0] HB_FIRE  = 32'(HEARTBEAT_CYCLES - 2);
    localparam logic [31:0] WD_LAST  = 32'(WATCHDOG_CYCLES - 1);
    localparam logic [31:0] WD_FIRE  = 32'(WATCHDOG_CYCLES - 2);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TMO_LAST = 16'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        SRC_ESTOP,
        SRC_WD,
        SRC_CNN,
        SRC_HB
    } src_t;

    state_t      state_q;
    src_t        src_q;
    src_t        sel_src;
    logic [7:0]  sel_frame;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic [2:0]  last_cmd_q;
    logic [15:0] frames_q;
    logic [15:0] timer_q;

    logic        estop_pend_q, estop_pend_d;
    logic        wd_pend_q, wd_pend_d;
    logic        cnn_pend_q, cnn_pend_d;
    logic        hb_pend_q, hb_pend_d;
    logic [2:0]  cnn_cmd_q, cnn_cmd_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic [31:0] hb_cnt_q, hb_cnt_d;
    logic        wd_trip_q, wd_trip_d;

    logic        any_pend;
    logic        launch_go;
    logic        wd_fire;
    logic        hb_fire;

    // Pick the highest-priority pending request and build its frame byte.
    always_comb begin
        sel_src   = SRC_HB;
        sel_frame = {5'b01010, last_cmd_q};
        if (estop_pend_q) begin
            sel_src   = SRC_ESTOP;
            sel_frame = 8'hF8;
        end else if (wd_pend_q) begin
            sel_src   = SRC_WD;
            sel_frame = 8'hA8;
        end else if (cnn_pend_q) begin
            sel_src   = SRC_CNN;
            sel_frame = {5'b10101, cnn_cmd_q};
        end
    end

    assign any_pend  = estop_pend_q | wd_pend_q | cnn_pend_q | hb_pend_q;
    assign launch_go = (state_q == ST_IDLE) && any_pend && !tx_busy;
    assign wd_fire   = !cnn_cmd_valid && (wd_cnt_q == WD_FIRE);
    assign hb_fire   = !tx_start_q && (hb_cnt_q == HB_FIRE);

    // Next-state for request flags and timers; a new request wins over the launch-time clear.
    always_comb begin
        estop_pend_d = estop_pend_q;
        wd_pend_d    = wd_pend_q;
        cnn_pend_d   = cnn_pend_q;
        hb_pend_d    = hb_pend_q;
        cnn_cmd_d    = cnn_cmd_q;
        wd_cnt_d     = wd_cnt_q;
        hb_cnt_d     = hb_cnt_q;
        wd_trip_d    = wd_trip_q;

        if (launch_go) begin
            case (sel_src)
                SRC_ESTOP: estop_pend_d = 1'b0;
                SRC_WD:    wd_pend_d    = 1'b0;
                SRC_CNN:   cnn_pend_d   = 1'b0;
                default:   hb_pend_d    = 1'b0;
            endcase
        end

        if (estop_req) begin
            estop_pend_d = 1'b1;
        end

        if (cnn_cmd_valid) begin
            cnn_pend_d = 1'b1;
            cnn_cmd_d  = cnn_cmd;
            wd_cnt_d   = '0;
            wd_trip_d  = 1'b0;
        end else if (wd_cnt_q != WD_LAST) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
        end

        if (wd_fire) begin
            wd_pend_d = 1'b1;
            wd_trip_d = 1'b1;
        end

        if (tx_start_q) begin
            hb_cnt_d = '0;
        end else if (hb_cnt_q != HB_LAST) begin
            hb_cnt_d = hb_cnt_q + 32'd1;
        end

        if (hb_fire) begin
            hb_pend_d = 1'b1;
        end
    end

    // Request flag and timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estop_pend_q <= 1'b0;
            wd_pend_q    <= 1'b0;
            cnn_pend_q   <= 1'b0;
            hb_pend_q    <= 1'b0;
            cnn_cmd_q    <= '0;
            wd_cnt_q     <= '0;
            hb_cnt_q     <= '0;
            wd_trip_q    <= 1'b0;
        end else begin
            estop_pend_q <= estop_pend_d;
            wd_pend_q    <= wd_pend_d;
            cnn_pend_q   <= cnn_pend_d;
            hb_pend_q    <= hb_pend_d;
            cnn_cmd_q    <= cnn_cmd_d;
            wd_cnt_q     <= wd_cnt_d;
            hb_cnt_q     <= hb_cnt_d;
            wd_trip_q    <= wd_trip_d;
        end
    end

    // Frame FSM: launch, wait for the master to take it, retry on no response, then enforce the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_ESTOP;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            last_cmd_q <= '0;
            frames_q   <= '0;
            timer_q    <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch_go) begin
                        state_q    <= ST_LAUNCH;
                        src_q      <= sel_src;
                        tx_data_q  <= sel_frame;
                        tx_start_q <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_WAIT_BUSY;
                    timer_q <= '0;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (timer_q == TMO_LAST) begin
                        state_q    <= ST_LAUNCH;
                        tx_start_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q  <= ST_GAP;
                        timer_q  <= '0;
                        frames_q <= frames_q + 16'd1;
                        if (src_q != SRC_HB) begin
                            last_cmd_q <= tx_data_q[2:0];
                        end
                    end
                end
                ST_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_data          = tx_data_q;
    assign tx_start         = tx_start_q;
    assign watchdog_tripped = wd_trip_q;
    assign last_cmd         = last_cmd_q;
    assign frames_sent      = frames_q;
    assign sched_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// tb/tb_motor_cmd_scheduler.sv - directed vector bench for motor_cmd_scheduler
module tb_motor_cmd_scheduler;

    localparam int unsigned HB  = 200;
    localparam int unsigned WD  = 100;
    localparam int unsigned GAP = 16;
    localparam int unsigned STO = 4;

    logic        clk;
    logic        rst_n;
    logic        estop_req;
    logic        cnn_cmd_valid;
    logic [2:0]  cnn_cmd;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        watchdog_tripped;
    logic [2:0]  last_cmd;
    logic [15:0] frames_sent;
    logic        sched_busy;

    motor_cmd_scheduler #(
        .HEARTBEAT_CYCLES(HB),
        .WATCHDOG_CYCLES (WD),
        .GAP_CYCLES      (GAP),
        .START_TIMEOUT   (STO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .estop_req       (estop_req),
        .cnn_cmd_valid   (cnn_cmd_valid),
        .cnn_cmd         (cnn_cmd),
        .tx_busy         (tx_busy),
        .tx_data         (tx_data),
        .tx_start        (tx_start),
        .watchdog_tripped(watchdog_tripped),
        .last_cmd        (last_cmd),
        .frames_sent     (frames_sent),
        .sched_busy      (sched_busy)
    );

    typedef struct {
        logic        estop;
        logic        cv;
        logic [2:0]  cmd;
        logic [7:0]  f0;
        logic        two;
        logic [7:0]  f1;
        logic [2:0]  last;
        logic [15:0] nsent;
    } vec_t;

    vec_t vecs[6];

    int unsigned cyc;
    int unsigned lcyc[$];
    logic [7:0]  ldat[$];
    int          nvec;
    int          nerr;
    logic        slave_en;
    int          busy_len;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) begin
            lcyc.push_back(cyc);
            ldat.push_back(tx_data);
        end
    end

    // SPI master model: busy rises half a cycle after tx_start, held for busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (slave_en && tx_start && rst_n) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        estop_req = 1'b0;
        cnn_cmd_valid = 1'b0;
        cnn_cmd = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lcyc.delete();
        ldat.delete();
    endtask

    task automatic pulse(input logic e, input logic v, input logic [2:0] c, output int unsigned at);
        @(posedge clk);
        #1;
        estop_req = e;
        cnn_cmd_valid = v;
        cnn_cmd = c;
        at = cyc;
        @(posedge clk);
        #1;
        estop_req = 1'b0;
        cnn_cmd_valid = 1'b0;
    endtask

    task automatic wait_frames(input logic [15:0] n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frames_sent == n && !sched_busy) break;
        end
        check("wait_frames_in_budget", 32'(i < budget), 32'd1);
    endtask

    initial begin
        int unsigned at;
        int i;
        nvec = 0;
        nerr = 0;
        slave_en = 1'b1;
        busy_len = 3;
        rst_n = 1'b0;
        estop_req = 1'b0;
        cnn_cmd_valid = 1'b0;
        cnn_cmd = 3'b000;

        vecs[0] = '{1'b0, 1'b1, 3'b001, 8'hA9, 1'b0, 8'h00, 3'b001, 16'd1};
        vecs[1] = '{1'b0, 1'b1, 3'b010, 8'hAA, 1'b0, 8'h00, 3'b010, 16'd1};
        vecs[2] = '{1'b0, 1'b1, 3'b000, 8'hA8, 1'b0, 8'h00, 3'b000, 16'd1};
        vecs[3] = '{1'b1, 1'b0, 3'b000, 8'hF8, 1'b0, 8'h00, 3'b000, 16'd1};
        vecs[4] = '{1'b1, 1'b1, 3'b010, 8'hF8, 1'b1, 8'hAA, 3'b010, 16'd2};
        vecs[5] = '{1'b1, 1'b1, 3'b001, 8'hF8, 1'b1, 8'hA9, 3'b001, 16'd2};

        // reset state, sampled while reset is held
        repeat (2) @(negedge clk);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_frames", 32'(frames_sent), 32'h0);
        check("rst_last_cmd", 32'(last_cmd), 32'h0);
        check("rst_wd_tripped", 32'(watchdog_tripped), 32'h0);
        check("rst_sched_busy", 32'(sched_busy), 32'h0);

        // single-request and same-cycle priority vectors
        for (int v = 0; v < 6; v++) begin
            do_reset();
            pulse(vecs[v].estop, vecs[v].cv, vecs[v].cmd, at);
            wait_frames(vecs[v].nsent, 300);
            check("vec_launch_count", 32'(lcyc.size()), vecs[v].two ? 32'd2 : 32'd1);
            if (lcyc.size() >= 1) begin
                check("vec_frame0", 32'(ldat[0]), 32'(vecs[v].f0));
                check("vec_latency", lcyc[0], at + 2);
            end
            if (vecs[v].two && lcyc.size() >= 2) begin
                check("vec_frame1", 32'(ldat[1]), 32'(vecs[v].f1));
                check("vec_gap", lcyc[1] - lcyc[0], 32'(busy_len) + GAP + 2);
            end
            check("vec_last_cmd", 32'(last_cmd), 32'(vecs[v].last));
            check("vec_frames", 32'(frames_sent), 32'(vecs[v].nsent));
            check("vec_tx_data_held", 32'(tx_data), vecs[v].two ? 32'(vecs[v].f1) : 32'(vecs[v].f0));
        end

        // latest CNN command wins while a frame is in flight
        do_reset();
        busy_len = 10;
        pulse(1'b0, 1'b1, 3'b001, at);
        repeat (2) @(posedge clk);
        pulse(1'b0, 1'b1, 3'b001, at);
        pulse(1'b0, 1'b1, 3'b010, at);
        pulse(1'b0, 1'b1, 3'b000, at);
        @(negedge clk);
        check("inflight_sched_busy", 32'(sched_busy), 32'd1);
        wait_frames(16'd2, 200);
        repeat (40) @(negedge clk);
        check("latest_launch_count", 32'(lcyc.size()), 32'd2);
        if (ldat.size() >= 2) check("latest_frame", 32'(ldat[1]), 32'hA8);
        check("latest_last_cmd", 32'(last_cmd), 32'h0);
        busy_len = 3;

        // watchdog expiry, single request, then heartbeat, then clear by CNN
        do_reset();
        for (i = 0; i < 150; i++) begin
            @(negedge clk);
            if (watchdog_tripped) break;
        end
        check("wd_tripped_set", 32'(watchdog_tripped), 32'd1);
        wait_frames(16'd1, 60);
        if (ldat.size() >= 1) check("wd_frame", 32'(ldat[0]), 32'hA8);
        repeat (150) @(negedge clk);
        check("wd_once", 32'(lcyc.size()), 32'd1);
        wait_frames(16'd2, 100);
        if (ldat.size() >= 2) check("hb_frame", 32'(ldat[1]), 32'h50);
        check("hb_last_cmd", 32'(last_cmd), 32'h0);
        check("hb_wd_still", 32'(watchdog_tripped), 32'd1);
        pulse(1'b0, 1'b1, 3'b010, at);
        @(negedge clk);
        check("wd_cleared", 32'(watchdog_tripped), 32'd0);
        wait_frames(16'd3, 100);
        if (ldat.size() >= 3) check("wd_cnn_frame", 32'(ldat[2]), 32'hAA);
        check("wd_cnn_last", 32'(last_cmd), 32'b010);

        // start timeout retry with a silent master
        do_reset();
        slave_en = 1'b0;
        pulse(1'b1, 1'b0, 3'b000, at);
        repeat (18) @(negedge clk);
        check("retry_count", 32'(lcyc.size()), 32'd4);
        if (lcyc.size() >= 3) begin
            check("retry_period1", lcyc[1] - lcyc[0], STO + 1);
            check("retry_period2", lcyc[2] - lcyc[1], STO + 1);
            check("retry_data1", 32'(ldat[1]), 32'hF8);
            check("retry_data2", 32'(ldat[2]), 32'hF8);
        end
        check("retry_frames", 32'(frames_sent), 32'd0);
        slave_en = 1'b1;
        wait_frames(16'd1, 100);
        check("retry_done_last", 32'(last_cmd), 32'h0);

        // reset during WAIT_DONE
        do_reset();
        busy_len = 20;
        pulse(1'b0, 1'b1, 3'b010, at);
        repeat (6) @(negedge clk);
        check("midframe_busy", 32'(sched_busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_tx_data", 32'(tx_data), 32'h0);
        check("arst_tx_start", 32'(tx_start), 32'h0);
        check("arst_sched_busy", 32'(sched_busy), 32'h0);
        check("arst_frames", 32'(frames_sent), 32'h0);
        check("arst_last_cmd", 32'(last_cmd), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        i = lcyc.size();
        repeat (40) @(negedge clk);
        check("arst_no_launch", 32'(lcyc.size()), 32'(i));
        check("arst_idle", 32'(sched_busy), 32'd0);
        busy_len = 3;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
